// File: rtl/hazard_pkg.sv
// hazard_pkg: mode encoding, light patterns and step counts shared by the hazard sequencer
package hazard_pkg;

  typedef enum logic [1:0] {
    CALM  = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2
  } mode_e;

  localparam logic [2:0] PAT_CALM0 = 3'b101;
  localparam logic [2:0] PAT_CALM1 = 3'b010;
  localparam logic [2:0] PAT_R0    = 3'b100;
  localparam logic [2:0] PAT_R1    = 3'b010;
  localparam logic [2:0] PAT_R2    = 3'b001;
  localparam logic [2:0] PAT_L0    = 3'b001;
  localparam logic [2:0] PAT_L1    = 3'b010;
  localparam logic [2:0] PAT_L2    = 3'b100;

  localparam logic [1:0] NUM_STEPS_CALM  = 2'd2;
  localparam logic [1:0] NUM_STEPS_RIGHT = 2'd3;
  localparam logic [1:0] NUM_STEPS_LEFT  = 2'd3;

  // Unused mode code 3 reports zero steps so every step value is out of range for it
  function automatic logic [1:0] num_steps(input logic [1:0] m);
    return m == CALM  ? NUM_STEPS_CALM  :
           m == RIGHT ? NUM_STEPS_RIGHT :
           m == LEFT  ? NUM_STEPS_LEFT  : 2'd0;
  endfunction

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    return m == CALM ? RIGHT : m == RIGHT ? LEFT : CALM;
  endfunction

  function automatic logic [2:0] pattern(input logic [1:0] m, input logic [1:0] s);
    return m == CALM  ? (s == 2'd0 ? PAT_CALM0 : s == 2'd1 ? PAT_CALM1 : 3'b000) :
           m == RIGHT ? (s == 2'd0 ? PAT_R0 : s == 2'd1 ? PAT_R1 : s == 2'd2 ? PAT_R2 : 3'b000) :
           m == LEFT  ? (s == 2'd0 ? PAT_L0 : s == 2'd1 ? PAT_L1 : s == 2'd2 ? PAT_L2 : 3'b000) :
           3'b000;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider that pulses tick once every TICK_DIV cycles
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count_q, count_d;

  assign tick = count_q == LAST;

  // Restart on clear; counts beyond LAST (non-power-of-two divisors) also wrap to zero
  always_comb begin
    count_d = (clear || count_q >= LAST) ? '0 : count_q + W'(1);
  end

  // Counter register, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: cycles wind mode on each button pulse and steps the hazard-light pattern
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_pulse,
  output logic [1:0] mode,
  output logic [2:0] lights
);

  logic [1:0] mode_q, mode_d;
  logic [1:0] step_q, step_d;
  logic       tick;
  logic       illegal;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clear (mode_pulse),
    .tick  (tick)
  );

  assign illegal = step_q >= num_steps(mode_q);

  // Illegal state recovers first, a pulse beats a tick, otherwise tick advances the step
  always_comb begin
    mode_d = illegal ? CALM : mode_pulse ? next_mode(mode_q) : mode_q;
    step_d = (illegal || mode_pulse) ? 2'd0 :
             tick ? (step_q == num_steps(mode_q) - 2'd1 ? 2'd0 : step_q + 2'd1) :
             step_q;
  end

  // Mode and step registers; reset lands on CALM step 0 without waiting for a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= CALM;
      step_q <= 2'd0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  // Outputs decode only registered state, so mode_pulse never reaches the pins combinationally
  always_comb begin
    mode   = mode_q;
    lights = illegal ? 3'b000 : pattern(mode_q, step_q);
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Consumes the single-cycle button-release pulse produced by the team's button-input FSM and drives the three hazard lights. Each pulse advances the wind mode CALM → RIGHT → LEFT → CALM. A prescaler steps the light pattern of the current mode at a fixed rate. The block sits between the button-input stage and the LED pins.

## Interface

Parameters:
- TICK_DIV, default 4: clock cycles per pattern step. Legal values are ≥ 2; the board build uses 2^24, simulation uses 4.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode_pulse  input  1  one-cycle advance request, synchronous to clk; comes from the button-input stage.
- mode  output  2  current mode: 0 = CALM, 1 = RIGHT, 2 = LEFT. Code 3 never appears.
- lights  output  3  LED drive; bit 2 is the leftmost LED, bit 0 the rightmost.

## Operation

- State held in registers:
  - mode register (2 bits).
  - step index (2 bits, range 0..2).
  - prescaler count (width $clog2(TICK_DIV), range 0..TICK_DIV-1).
- Reset (reset low), asynchronous:
  - mode = CALM, step = 0, count = 0, lights = 3'b101.
  - Outputs take these values immediately, without waiting for a clock edge, and hold them while reset is low.
- Prescaler:
  - count increments every cycle.
  - tick is asserted when count == TICK_DIV-1; on that cycle count wraps to 0.
- Mode advance:
  - Any cycle with mode_pulse = 1 sets mode to the next mode: CALM→RIGHT→LEFT→CALM.
  - The same edge clears step to 0 and count to 0.
  - A pulse held high for N cycles advances the mode N times. The block does not detect edges on mode_pulse.
- Step advance: on tick with no pulse, step increments and wraps:
  - CALM: 0→1→0.
  - RIGHT and LEFT: 0→1→2→0.
- Patterns (lights as a function of mode and step):
  - CALM: step 0 = 101, step 1 = 010.
  - RIGHT: 100, 010, 001.
  - LEFT: 001, 010, 100.
- Simultaneous pulse and tick: the pulse wins. Mode advances, step = 0, count = 0.
- Illegal encodings: mode = 3 or step = 3 recovers to CALM / step 0 on the next edge. lights = 3'b000 while an illegal encoding is present.

## Timing

- lights and mode are decoded only from registered state. There is no combinational path from mode_pulse to any output.
- Pulse sampled at edge k: mode and lights show the new mode's step-0 pattern after edge k. The next step change happens TICK_DIV edges later.
- Steady state: each pattern is held for exactly TICK_DIV cycles.
- Reset release: the first step change occurs TICK_DIV rising edges after reset deasserts.
- Reset mid-operation: any mode, step or count is abandoned. Outputs return to CALM/101 asynchronously.

## Structure

- Package hazard_pkg holds:
  - mode_e enum: CALM=2'd0, RIGHT=2'd1, LEFT=2'd2.
  - Pattern constants: PAT_CALM0=3'b101, PAT_CALM1=3'b010, PAT_R0/1/2, PAT_L0/1/2.
  - NUM_STEPS for each mode.
- Sub-module tick_prescaler:
  - Inputs: clk, reset, clear.
  - Output: tick.
  - Parameterised by TICK_DIV.
  - clear is driven by mode_pulse.
- The mode FSM, step counter and pattern decode stay in hazard_sequencer.

## Test plan

All scenarios use TICK_DIV = 4.

1. Reset, then idle for 12 cycles:
   - lights = 101 at reset release.
   - 010 after 4 edges, 101 after 8, 010 after 12.
   - mode = 0 throughout.
2. Single one-cycle pulse at cycle 6:
   - mode = 1 and lights = 100 after that edge.
   - 010 four edges later, then 001, then 100 again.
3. Three pulses spaced 10 cycles apart:
   - mode sequence is 1, 2, 0.
   - lights = 001 on entry to LEFT and 101 on return to CALM.
4. Pulse on the cycle where count = 3 (tick) in CALM step 0:
   - Result is mode = 1, lights = 100, count = 0.
   - lights does not show 010.
5. mode_pulse held high for 2 cycles from CALM:
   - mode = 2, lights = 001.
   - The next step change occurs 4 edges after the pulse falls.
6. In RIGHT with lights = 010, drive reset low midway between clock edges:
   - lights = 101 and mode = 0 before the next rising edge.
   - Both hold while reset is low.
   - After release, the pattern resumes per scenario 1.
